sram_mem_controller: RTL
========================

# sram_mem_controller

Multi-cycle data-memory controller for the MEM stage of the pipelined ARM core. It accepts one 32-bit load or store per request from the EXE/MEM register and performs it as two 16-bit accesses on an external asynchronous SRAM, with programmable wait states. It produces the load value that feeds the MEM/WB register's memory-read input and a `ready` flag that freezes the pipeline until the access completes.

## Interface

- ADDR_BASE, 1024: byte address that maps to SRAM halfword 0.
- SRAM_AW, 18: SRAM address width (halfword addressing).
- WAIT_CYCLES, 5: cycles per 16-bit access; legal values are ≥ 2.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- rd_en  input  1  load request (MEM_R_EN from EXE/MEM).
- wr_en  input  1  store request (MEM_W_EN from EXE/MEM).
- address  input  32  byte address (ALU result); bits [1:0] ignored.
- wdata  input  32  store data (Val_Rm).
- rdata  output  32  load data to the MEM/WB register.
- ready  output  1  access complete or idle; the pipeline freezes while this is 0.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  SRAM_AW  SRAM halfword address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low chip enable, output enable and write enable.
- SRAM_UB_N, SRAM_LB_N  output  1 each  byte enables, tied to 0.

## Operation

- States:
  - IDLE: no access.
  - LO: low halfword access.
  - HI: high halfword access.
  - DONE: one cycle, access complete.
- `req = rd_en | wr_en`. If both enables are 1, the request is a write.
- Halfword addresses:
  - `off = address - ADDR_BASE`.
  - LO address = `{off[SRAM_AW:2], 1'b0}`.
  - HI address = `{off[SRAM_AW:2], 1'b1}`.
  - Arithmetic is 32-bit modulo; upper bits are truncated.
- Data layout is little-endian. LO carries `wdata[15:0]` / `rdata[15:0]`; HI carries bits [31:16].
- Transitions:
  - IDLE→LO when `req` is 1.
  - LO→HI when the wait counter reaches WAIT_CYCLES-1.
  - HI→DONE on the same condition.
  - DONE→IDLE always.
- The wait counter resets to 0 on every state entry. Its width is `$clog2(WAIT_CYCLES)`.
- `ready` is combinational:
  - IDLE: `ready = ~req`.
  - DONE: `ready = 1`.
  - LO, HI: `ready = 0`.
- Request inputs must stay stable from IDLE until the cycle in which `ready` = 1. The core freezes them.
- SRAM bus during LO/HI:
  - SRAM_CE_N = 0.
  - Read: SRAM_OE_N = 0 for the whole access.
  - Write: SRAM_WE_N = 0 in every access cycle except the last one (data hold). SRAM_DQ drives the halfword for the whole access.
- SRAM bus in IDLE and DONE: CE_N, OE_N and WE_N = 1; SRAM_DQ is high-Z.
- SRAM_DQ is driven only during write accesses and is high-Z otherwise.
- Reads: `rdata[15:0]` captures SRAM_DQ on the last-cycle edge of LO; `rdata[31:16]` captures it on the last-cycle edge of HI. `rdata` holds its value until the next read overwrites it. Writes never change `rdata`.

## Timing

- Reset values, applied asynchronously on `reset_n` = 0:
  - State = IDLE, counter = 0, `rdata` = 0.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N = 1.
  - SRAM_DQ = high-Z; SRAM_ADDR = 0.
  - `ready = ~req`.
- Latency: the request is first seen in cycle 0 (IDLE, `ready` = 0).
  - LO occupies cycles 1..W and HI occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready` = 1 and `rdata` valid.
  - With W = 5, `ready` rises in cycle 11.
- Back-to-back: a new request present in the cycle after DONE starts again from IDLE (a 1-cycle bubble).
- Reset during LO, HI or DONE aborts the access. The SRAM controls deassert immediately, the partial `rdata` is cleared, and any partially written SRAM word is undefined.
- SRAM_ADDR is stable for the whole of each access and changes only on state transitions.

## Structure

- Package `arm_mem_pkg` holds:
  - the `sram_state_t` enum (IDLE, LO, HI, DONE);
  - the constants `ADDR_BASE_DEFAULT` (1024) and `SRAM_DW` (16).
- Single module. No sub-module is needed; the counter, FSM and tristate driver are all local.

## Test plan

- Reset: hold `reset_n` = 0 with `rd_en` = 1, then release. During reset: `rdata` = 0, CE_N/WE_N/OE_N = 1, DQ high-Z, `ready` = 0.
- Store 0xDEADBEEF to 1024, W = 5:
  - SRAM_ADDR 0 with DQ 0xBEEF in cycles 1–5, WE_N low in cycles 1–4.
  - SRAM_ADDR 1 with DQ 0xDEAD in cycles 6–10.
  - `ready` = 1 in cycle 11 only.
- Load from 1024 after that store (with an SRAM model): OE_N low in cycles 1–10, `rdata` = 0xDEADBEEF in cycle 11, held afterwards.
- Store 0x12345678 to 1028, then a load from 1028 the cycle after DONE: SRAM addresses 2/3, one IDLE bubble, `rdata` = 0x12345678.
- Assert `reset_n` = 0 in cycle 7 of a load: controls deassert in the same cycle, state returns to IDLE, `rdata` = 0, no DONE pulse.
- No request for 20 cycles: `ready` stays 1 and CE_N stays 1. With `rd_en` = `wr_en` = 1 the controller performs a write (WE_N toggles, OE_N stays 1).

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM core data-memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_mem_pkg;

    // Access sequencer states: idle, low halfword, high halfword, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int unsigned ADDR_BASE_DEFAULT = 1024;
    localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_mem_controller.sv
// 32-bit load/store as two 16-bit accesses (low then high) on an async SRAM.
// Latency: request seen in cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1.
// Backpressure: ready=0 while an access is pending; requester holds inputs stable.
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         address,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                ready,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    sram_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 req;
    logic                 busy;
    logic                 last;
    logic [31:0]          off;
    logic [SRAM_AW-1:0]   lo_addr;
    logic                 dq_oe;
    logic [SRAM_DW-1:0]   dq_out;
    logic                 unused_addr_bits;

    assign req  = rd_en | wr_en;
    assign busy = (state_q == LO) || (state_q == HI);
    assign last = (cnt_q == CNT_LAST);

    // Halfword index of the word; low half is even, high half is odd.
    assign off              = address - 32'(ADDR_BASE);
    assign lo_addr          = {off[SRAM_AW:2], 1'b0};
    assign unused_addr_bits = ^{off[31:SRAM_AW+1], off[1:0]};

    // Sequencer: state, per-access wait counter, latched address/direction, read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    addr_d  = lo_addr;
                    wr_d    = wr_en;     // write wins when both enables are set
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
                    if (!wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous abort on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM strobes decoded straight from state so reset releases them immediately.
    // WE_N rises one cycle before the access ends to give the SRAM data hold time.
    always_comb begin
        SRAM_CE_N = ~busy;
        SRAM_OE_N = ~(busy & ~wr_q);
        SRAM_WE_N = ~(busy & wr_q & ~last);
        dq_oe     = busy & wr_q;
        dq_out    = (state_q == HI) ? wdata[31:16] : wdata[15:0];
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign rdata = rdata_q;
    assign ready = (state_q == IDLE) ? ~req : (state_q == DONE);

endmodule
